// File: rtl/esl_nios_ii_system_cpu_jtag_scan_master.sv
// Host-side JTAG scan initiator for the Nios II debug TAP.
// Runs IR/DR scans from a valid/ready command port and returns captured TDO.
module esl_nios_ii_system_cpu_jtag_scan_master #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [5:0]          cmd_len,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    typedef enum logic [3:0] {
        TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP
    } state_t;

    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
    localparam logic [5:0] DR_MAX = 6'(DR_WIDTH);
    localparam logic [5:0] IR_LEN = 6'(IR_WIDTH);

    state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0] idx_q, idx_d;
    logic smp_q, smp_d;
    logic tck_d, tms_d, tdi_d;
    logic ready_d, busy_d, vld_d;

    logic [DR_WIDTH-1:0] data_q, cap_q;
    logic [5:0] len_q;
    logic ir_q, err_q;

    logic accept, bad_len, tick, rise, fall, active;

    assign accept  = cmd_valid && cmd_ready;
    assign bad_len = !cmd_is_ir && (cmd_len == 6'd0 || cmd_len > DR_MAX);
    assign tick    = div_q == DIV_LAST;
    assign rise    = tick && !tck;
    assign fall    = tick && tck;
    assign active  = state_q != IDLE && state_q != RESP;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        smp_d   = smp_q;
        tck_d   = tck;
        tms_d   = tms;
        tdi_d   = tdi;
        ready_d = cmd_ready;
        busy_d  = busy;
        vld_d   = 1'b0;
        if (active) begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) tck_d = !tck;
        end
        if (rise && smp_q) idx_d = idx_q + 6'd1;
        unique case (state_q)
            TLR_SEQ: if (fall) begin
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd4) tms_d = 1'b0;
                if (idx_q == 6'd5) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            IDLE: if (accept) begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                idx_d   = '0;
                div_d   = '0;
                smp_d   = 1'b0;
                tdi_d   = 1'b0;
                if (bad_len) begin
                    state_d = RESP;
                end else begin
                    state_d = SEL_DR;
                    tms_d   = 1'b1;
                end
            end
            SEL_DR: if (fall) begin
                state_d = ir_q ? SEL_IR : CAPTURE;
                tms_d   = ir_q;
            end
            SEL_IR: if (fall) begin
                state_d = CAPTURE;
                tms_d   = 1'b0;
            end
            CAPTURE: if (fall) begin
                state_d = SHIFT;
                tms_d   = 1'b0;
            end
            // idx counts bits already sampled, so it selects the next TDI bit
            SHIFT: if (fall) begin
                tdi_d = data_q[idx_q];
                smp_d = 1'b1;
                if (idx_q == len_q - 6'd1) begin
                    state_d = EXIT1;
                    tms_d   = 1'b1;
                end
            end
            EXIT1: if (fall) begin
                state_d = UPDATE;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
                smp_d   = 1'b0;
            end
            // tms still high means the Update->Idle edge is yet to come
            UPDATE: if (fall) begin
                if (tms) tms_d = 1'b0;
                else state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                vld_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = TLR_SEQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TLR_SEQ;
            div_q     <= '0;
            idx_q     <= '0;
            smp_q     <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            smp_q     <= smp_d;
            tck       <= tck_d;
            tms       <= tms_d;
            tdi       <= tdi_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            rsp_valid <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            cap_q    <= '0;
            len_q    <= '0;
            ir_q     <= 1'b0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                data_q <= cmd_data;
                len_q  <= cmd_is_ir ? IR_LEN : cmd_len;
                ir_q   <= cmd_is_ir;
                err_q  <= bad_len;
                cap_q  <= '0;
            end
            if (rise && smp_q) cap_q[idx_q] <= tdo;
            if (state_q == RESP) begin
                rsp_data <= cap_q;
                rsp_err  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_esl_nios_ii_system_cpu_jtag_scan_master.sv
// Scoreboard bench for the JTAG scan master against a behavioural TAP.
// Randomised IR/DR scans plus reset, illegal length and back-to-back cases.
module tb_esl_nios_ii_system_cpu_jtag_scan_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_is_ir = 1'b0;
    logic [5:0] cmd_len = '0;
    logic [37:0] cmd_data = '0;
    logic cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi, tdo;
    logic [37:0] rsp_data;

    esl_nios_ii_system_cpu_jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    logic f_ready, f_valid, f_err, f_busy, f_tck, f_tms, f_tdi;
    logic [37:0] f_data;
    logic f_cmd_valid = 1'b0, f_is_ir = 1'b0, f_tdo = 1'b0;
    logic [5:0] f_len = '0;
    logic [37:0] f_cmd_data = '0;

    esl_nios_ii_system_cpu_jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(1)) u_fast (
        .clk(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_ready),
        .cmd_is_ir(f_is_ir), .cmd_len(f_len), .cmd_data(f_cmd_data),
        .rsp_valid(f_valid), .rsp_data(f_data), .rsp_err(f_err), .busy(f_busy),
        .tck(f_tck), .tms(f_tms), .tdi(f_tdi), .tdo(f_tdo)
    );

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
        T_SIS, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_t;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            T_TLR:  return m ? T_TLR  : T_RTI;
            T_RTI:  return m ? T_SDS  : T_RTI;
            T_SDS:  return m ? T_SIS  : T_CDR;
            T_CDR:  return m ? T_E1DR : T_SHDR;
            T_SHDR: return m ? T_E1DR : T_SHDR;
            T_E1DR: return m ? T_UDR  : T_PDR;
            T_PDR:  return m ? T_E2DR : T_PDR;
            T_E2DR: return m ? T_UDR  : T_SHDR;
            T_UDR:  return m ? T_SDS  : T_RTI;
            T_SIS:  return m ? T_TLR  : T_CIR;
            T_CIR:  return m ? T_E1IR : T_SHIR;
            T_SHIR: return m ? T_E1IR : T_SHIR;
            T_E1IR: return m ? T_UIR  : T_PIR;
            T_PIR:  return m ? T_E2IR : T_PIR;
            T_E2IR: return m ? T_UIR  : T_SHIR;
            default: return m ? T_SDS : T_RTI;
        endcase
    endfunction

    tap_t tap = T_SHDR;
    logic loopback = 1'b0;
    logic [37:0] dr_cap = '0, dr_sr = '0;
    logic [1:0] ir_sr = '0;

    assign tdo = (tap == T_SHDR) ? (loopback ? tdi : dr_sr[0]) :
                 (tap == T_SHIR) ? ir_sr[0] : 1'b0;

    typedef struct {
        logic        err;
        logic [37:0] data;
        logic [37:0] tdi;
        logic [63:0] tms;
        int          edges;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(bit ir, logic [5:0] len, logic [37:0] d,
                                      bit lp, logic [37:0] cap);
        exp_t e;
        int n, k;
        logic [37:0] m;
        e.err = !ir && (len == 6'd0 || len > 6'd38);
        e.data = '0; e.tdi = '0; e.tms = '0; e.edges = 0;
        e.lat = e.err ? 2 : -1;
        if (e.err) return e;
        n = ir ? 2 : int'(len);
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        e.data  = ir ? 38'h1 : (lp ? (d & m) : (cap & m));
        e.tdi   = d & m;
        e.edges = n + (ir ? 6 : 5);
        e.tms[0] = 1'b1;
        k = 1;
        if (ir) begin e.tms[1] = 1'b1; k = 2; end
        k = k + 2 + n - 1;
        e.tms[k] = 1'b1;
        e.tms[k + 1] = 1'b1;
        return e;
    endfunction

    int cyc = 0, edge_cnt = 0, sh_cnt = 0, acc_cyc = 0;
    int last_rsp_cyc = -1, last_acc_cyc = -1;
    logic [63:0] tms_hist = '0;
    logic [37:0] tdi_hist = '0;
    logic tck_prev = 1'b0, f_prev = 1'b0;
    int f_rises = 0, f_last = 0, f_period = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tck && !tck_prev) begin
            if (edge_cnt < 64) tms_hist[edge_cnt] = tms;
            edge_cnt++;
            if (tap == T_SHDR || tap == T_SHIR) begin
                if (sh_cnt < 38) tdi_hist[sh_cnt] = tdi;
                sh_cnt++;
            end
            if (tap == T_CDR) dr_sr = dr_cap;
            if (tap == T_CIR) ir_sr = 2'b01;
            if (tap == T_SHDR) dr_sr = dr_sr >> 1;
            if (tap == T_SHIR) ir_sr = {tdi, ir_sr[1]};
            tap = tap_next(tap, tms);
        end
        tck_prev = tck;
        if (f_tck && !f_prev && !reset) begin
            if (f_rises == 1) f_period = cyc - f_last;
            f_last = cyc;
            f_rises++;
        end
        f_prev = f_tck;
        if (reset) begin
            edge_cnt = 0; sh_cnt = 0; tms_hist = '0; tdi_hist = '0;
            f_rises = 0;
        end
        if (rsp_valid) begin
            last_rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("tck_edges", 64'(edge_cnt), 64'(e.edges));
                check("tms_seq", tms_hist, e.tms);
                check("tdi_bits", 64'(tdi_hist), 64'(e.tdi));
                check("rsp_busy_ready", {62'd0, busy, cmd_ready}, 64'd1);
                if (!e.err) check("tap_in_rti", 64'(tap == T_RTI), 64'd1);
                if (e.lat >= 0) check("err_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
        if (cmd_valid && cmd_ready && !reset) begin
            acc_cyc = cyc;
            last_acc_cyc = cyc;
            edge_cnt = 0; sh_cnt = 0; tms_hist = '0; tdi_hist = '0;
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("ready_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_resp();
        int i;
        for (i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input bit ir, input logic [5:0] len, input logic [37:0] d,
                         input bit keep, input bit expect_rsp);
        bit ok;
        @(posedge clk); #1;
        cmd_is_ir = ir; cmd_len = len; cmd_data = d; cmd_valid = 1'b1;
        wait_ready(ok);
        if (ok && expect_rsp) sb.push_back(make_exp(ir, len, d, loopback, dr_cap));
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic tlr_check();
        bit ok;
        wait_ready(ok);
        check("tlr_edges", 64'(edge_cnt), 64'd6);
        check("tlr_tms", tms_hist, 64'h1F);
        check("tlr_idle", {62'd0, busy, cmd_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] r;
        int b2b_rsp;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {57'd0, tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy}, 64'b0100001);
        check("reset_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("busy_after_reset", 64'(busy), 64'd1);
        tlr_check();

        loopback = 1'b0;
        issue(1'b1, 6'd0, 38'h2, 1'b0, 1'b1);
        wait_resp();

        loopback = 1'b1;
        issue(1'b0, 6'd38, 38'h2A_5555_AAAA, 1'b0, 1'b1);
        wait_resp();

        issue(1'b0, 6'd0, 38'h3F_FFFF_FFFF, 1'b0, 1'b1);
        wait_resp();
        issue(1'b0, 6'd39, 38'h12_3456_789A, 1'b0, 1'b1);
        wait_resp();

        loopback = 1'b1;
        issue(1'b0, 6'd38, 38'h15_AAAA_5555, 1'b0, 1'b0);
        for (int i = 0; i < 2000 && sh_cnt < 10; i++) @(negedge clk);
        check("reached_bit10", 64'(sh_cnt >= 10), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tlr_check();
        loopback = 1'b0;
        issue(1'b1, 6'd0, 38'h1, 1'b0, 1'b1);
        wait_resp();

        r = {$urandom, $urandom};
        dr_cap = r[37:0];
        issue(1'b0, 6'd5, 38'h0A, 1'b1, 1'b1);
        issue(1'b0, 6'd7, 38'h55, 1'b0, 1'b1);
        b2b_rsp = last_rsp_cyc;
        @(negedge clk);
        check("b2b_accept_cycle", 64'(last_acc_cyc), 64'(b2b_rsp));
        check("b2b_busy", {62'd0, busy, cmd_ready}, 64'd2);
        wait_resp();

        for (int t = 0; t < 16; t++) begin
            r = {$urandom, $urandom};
            dr_cap = r[37:0];
            loopback = 1'($urandom_range(0, 1));
            r = {$urandom, $urandom};
            issue(($urandom_range(0, 3) == 0), 6'($urandom_range(0, 40)), r[37:0], 1'b0, 1'b1);
            wait_resp();
        end

        check("fast_tck_period", 64'(f_period), 64'd2);
        check("fast_tlr_edges", 64'(f_rises), 64'd6);
        check("fast_ready", 64'(f_ready), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
